// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default sizes.
package reg_file_mp_pkg;

    localparam int DEFAULT_DATA_W = 24;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with registered reads, write-through bypass
// and a sequential clear that runs after reset and on request.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Rw,
    input  logic              enWrite,
    input  logic [DATA_W-1:0] BusW,
    input  logic              clr_req,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    rf_state_t         r_state;
    rf_state_t         w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_last;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_last = (r_cnt == {ADDR_W{1'b1}});
    assign w_we   = (r_state == ST_IDLE) && enWrite &&
                    !((ZERO_R0 != 0) && (Rw == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (clr_req) w_next_state = ST_CLEAR;
            ST_CLEAR: if (w_last)  w_next_state = ST_IDLE;
            default:  w_next_state = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_CLEAR);
    end

    // Bypass first, then the hard-wired zero so address 0 wins even on a same-cycle write.
    always_comb begin
        w_rd_a = r_mem[Ra];
        if (enWrite && (Rw == Ra)) w_rd_a = BusW;
        if ((ZERO_R0 != 0) && (Ra == '0)) w_rd_a = '0;
        w_rd_b = r_mem[Rb];
        if (enWrite && (Rw == Rb)) w_rd_b = BusW;
        if ((ZERO_R0 != 0) && (Rb == '0)) w_rd_b = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BusA  <= '0;
            BusB  <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            BusA  <= '0;
            BusB  <= '0;
            r_cnt <= r_cnt + ADDR_W'(1);
        end else begin
            BusA  <= w_rd_a;
            BusB  <= w_rd_b;
            r_cnt <= '0;
        end
    end

    // Storage has no reset; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_we) begin
            r_mem[Rw] <= BusW;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed checks of reg_file_mp (ZERO_R0=0 and ZERO_R0=1 side by side)
// against an array-based reference model.
module tb_reg_file_mp;

    localparam int DW    = 24;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra, rb, rw;
    logic          we, clr;
    logic [DW-1:0] busw;
    logic [DW-1:0] a0, b0, a1, b1;
    logic          busy0, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] m_mem [2][DEPTH];
    logic [DW-1:0] eA [2];
    logic [DW-1:0] eB [2];
    int            clear_left;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) u_dut0 (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .enWrite(we),
        .BusW(busw), .clr_req(clr), .BusA(a0), .BusB(b0), .busy(busy0)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) u_dut1 (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .enWrite(we),
        .BusW(busw), .clr_req(clr), .BusA(a1), .BusB(b1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == '0) return '0;
        if (we && rw == a) return busw;
        return m_mem[z][a];
    endfunction

    // Advance one clock: update the model from the current inputs, then compare after the edge.
    task automatic step();
        if (clear_left > 0) begin
            for (int z = 0; z < 2; z++) begin
                m_mem[z][DEPTH - clear_left] = '0;
                eA[z] = '0;
                eB[z] = '0;
            end
            clear_left--;
        end else begin
            for (int z = 0; z < 2; z++) begin
                eA[z] = m_read(z, ra);
                eB[z] = m_read(z, rb);
            end
            for (int z = 0; z < 2; z++) begin
                if (we && !(z == 1 && rw == '0)) m_mem[z][rw] = busw;
            end
            if (clr) clear_left = DEPTH;
        end
        @(posedge clk);
        #1;
        check("busy0", 32'(busy0), 32'(clear_left > 0));
        check("busy1", 32'(busy1), 32'(clear_left > 0));
        check("BusA_z0", 32'(a0), 32'(eA[0]));
        check("BusB_z0", 32'(b0), 32'(eB[0]));
        check("BusA_z1", 32'(a1), 32'(eA[1]));
        check("BusB_z1", 32'(b1), 32'(eB[1]));
    endtask

    task automatic idle_in();
        we = 1'b0; clr = 1'b0; rw = '0; ra = '0; rb = '0; busw = '0;
    endtask

    // Called 1 time unit after a rising edge; pulses reset between edges.
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd1);
        check("rst_BusA0", 32'(a0), 32'd0);
        check("rst_BusB1", 32'(b1), 32'd0);
        #1;
        rst = 1'b0;
        clear_left = DEPTH;
        for (int z = 0; z < 2; z++) begin
            eA[z] = '0;
            eB[z] = '0;
        end
    endtask

    task automatic read_all_zero(input string tag);
        idle_in();
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i);
            rb = AW'(DEPTH - 1 - i);
            step();
            check(tag, 32'(a0 | b0 | a1 | b1), 32'd0);
        end
    endtask

    initial begin
        idle_in();
        clear_left = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_pulse();

        // Clear after reset release: busy for exactly DEPTH cycles
        for (int i = 0; i < DEPTH; i++) step();
        check("busy_fell", 32'(busy0), 32'd0);
        read_all_zero("post_reset_zero");

        // Write then read next cycle
        we = 1'b1; rw = 3'd5; busw = 24'hABCDEF;
        step();
        we = 1'b0; ra = 3'd5;
        step();
        check("wr_rd_5", 32'(a0), 32'hABCDEF);

        // Same-cycle bypass on both ports
        we = 1'b1; rw = 3'd3; busw = 24'h123456; ra = 3'd3; rb = 3'd3;
        step();
        check("bypass_A", 32'(a0), 32'h123456);
        check("bypass_B", 32'(b0), 32'h123456);

        // Register 0 with ZERO_R0=1: write dropped, bypass suppressed
        we = 1'b1; rw = 3'd0; busw = 24'hFFFFFF; ra = 3'd0; rb = 3'd0;
        step();
        check("r0_same_z1", 32'(a1), 32'd0);
        check("r0_same_z0", 32'(a0), 32'hFFFFFF);
        we = 1'b0;
        step();
        check("r0_next_z1", 32'(b1), 32'd0);

        // Fill, request clear with a concurrent write, writes during clear ignored
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; rw = AW'(i); busw = DW'($urandom);
            step();
        end
        we = 1'b1; rw = 3'd2; busw = 24'h5A5A5A; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; rw = AW'($urandom_range(0, DEPTH - 1)); busw = DW'($urandom);
            clr = 1'($urandom_range(0, 1));
            step();
        end
        check("clr_done", 32'(busy1), 32'd0);
        read_all_zero("post_clear_zero");

        // Reset in the middle of a clear restarts it
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; rw = AW'(i); busw = DW'($urandom);
            step();
        end
        idle_in();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) step();
        read_all_zero("post_midrst_zero");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra   = AW'($urandom_range(0, DEPTH - 1));
            rb   = AW'($urandom_range(0, DEPTH - 1));
            rw   = AW'($urandom_range(0, DEPTH - 1));
            we   = 1'($urandom_range(0, 1));
            busw = DW'($urandom);
            clr  = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
